riscv_soft_mem_arbiter: RTL and testbench
=========================================

// Module: riscv_soft_mem_arbiter
// PURPOSE
//  Sits directly downstream of riscv_soft_i_cache and riscv_soft_d_cache inside the tile.
//  Merges their miss/refill and write-through traffic onto one memory port.
//  Single outstanding transaction, round-robin grant, burst line refills,
//  registered response routing back to the owning cache.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width, all ports
//  DATA_WIDTH  32  beat width, all data ports (multiple of 8)
//  LINE_BEATS  4   beats per read refill (power of 2, >=2)
// PORTS
//  clk            in   1           sole clock, rising edge
//  reset          in   1           asynchronous, active-low reset
//  i_req_valid    in   1           I-cache refill request
//  i_req_ready    out  1           I request accepted this cycle
//  i_req_addr     in   ADDR_WIDTH  refill address (line-aligned internally)
//  i_resp_valid   out  1           I refill beat valid
//  i_resp_data    out  DATA_WIDTH  I refill beat
//  i_resp_last    out  1           final beat of refill
//  d_req_valid    in   1           D-cache request
//  d_req_ready    out  1           D request accepted this cycle
//  d_req_we       in   1           1=single-beat write, 0=line refill
//  d_req_addr     in   ADDR_WIDTH  byte address
//  d_req_wdata    in   DATA_WIDTH  write data
//  d_req_wstrb    in   DATA_WIDTH/8 byte enables (write only)
//  d_resp_valid   out  1           D beat / write ack valid
//  d_resp_data    out  DATA_WIDTH  D refill beat (0 on write ack)
//  d_resp_last    out  1           final beat / write ack
//  mem_req_valid  out  1           memory request valid
//  mem_req_ready  in   1           memory accepts request
//  mem_req_we     out  1           write
//  mem_req_addr   out  ADDR_WIDTH  address
//  mem_req_wdata  out  DATA_WIDTH  write data
//  mem_req_wstrb  out  DATA_WIDTH/8 byte enables (0 for reads)
//  mem_resp_valid in   1           memory beat / write ack (no backpressure)
//  mem_resp_data  in   DATA_WIDTH  memory beat
//  stat_i_grants  out  32          I grants (see CONFIGURATION)
//  stat_d_grants  out  32          D grants
//  stat_conflicts out  32          cycles both requesters valid in IDLE
// BEHAVIOUR
//  - Reset (any time, incl. mid-burst): state=IDLE, beat count=0, last_grant=D,
//    all outputs 0; in-flight transaction is dropped, no response issued.
//  - FSM: IDLE -> REQ on grant; REQ -> RESP on mem_req_valid&mem_req_ready;
//    RESP -> IDLE on final beat (LINE_BEATS-th read beat, or 1st beat for write).
//  - Grant (IDLE only, combinational): one valid -> that port; both valid ->
//    port != last_grant; reset value makes I win first contest. x_req_ready=1
//    only for the granted port in that cycle; both readys 0 outside IDLE.
//  - Accept cycle N: request latched; mem_req_valid=1 from N+1, held stable
//    until mem_req_ready; last_grant updated at accept.
//  - Read address: low log2(LINE_BEATS*DATA_WIDTH/8) bits forced 0.
//    Write address passed unmodified; mem_req_wstrb=0 for reads.
//  - Responses registered: mem_resp_valid at cycle M -> owner x_resp_valid at M+1
//    for exactly one cycle; other port's resp_valid stays 0.
//  - Beat counter log2(LINE_BEATS) bits, wraps to 0 on last beat; x_resp_last=1 with it.
//  - mem_resp_valid in IDLE or REQ: ignored, no state change.
//  - Throughput: min 3 cycles between accepts for writes with zero memory latency.
// CONFIGURATION
//  Macro RISCV_SOFT_ARB_STATS_EN:
//  - defined: three 32-bit saturating counters (stick at 32'hFFFF_FFFF), reset 0;
//    i/d grants +1 per accept; conflicts +1 per IDLE cycle with both valid.
//  - undefined: counter logic omitted, stat_* outputs tied to 0.
// TESTING
//  - Reset release, i_req_valid=1 addr 0x104 -> i_req_ready next edge, mem_req_addr=0x100, we=0.
//  - Read, memory returns 0xA0..0xA3 -> i_resp_data 0xA0..0xA3 one cycle later, last on 0xA3.
//  - Both valid from reset -> I first, then D; repeat -> grants alternate I,D,I,D.
//  - D write addr 0x8 wdata 0xDEADBEEF wstrb 0xF, ack -> d_resp_valid/last=1, data 0.
//  - reset low during beat 2 of refill -> outputs 0 immediately; new req accepted after release.
//  - STATS_EN: 3 I + 2 D grants, 4 contention cycles -> stat values 3/2/4; undefined -> 0/0/0.

Source files
------------

// File: rtl/riscv_soft_mem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache traffic onto one memory port.
// Optional grant/conflict statistics counters are enabled by RISCV_SOFT_ARB_STATS_EN.
`timescale 1ns/1ps
module riscv_soft_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    output logic                    i_resp_last,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic                    d_req_we,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    d_resp_last,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic [31:0]             stat_i_grants,
    output logic [31:0]             stat_d_grants,
    output logic [31:0]             stat_conflicts
);

    localparam int unsigned BeatW = $clog2(LINE_BEATS);
    localparam int unsigned OffW  = $clog2(LINE_BEATS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        ~((ADDR_WIDTH'(1) << OffW) - ADDR_WIDTH'(1));
    localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e           state_q;
    logic             last_grant_q;  // 1 = D granted most recently
    logic             owner_q;       // 1 = D owns the in-flight transaction
    logic             we_q;
    logic [BeatW-1:0] beat_q;
    logic             gnt_i, gnt_d;
    logic             final_beat;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state_q == StIdle) begin
            if (i_req_valid && d_req_valid) begin
                gnt_i = last_grant_q;
                gnt_d = !last_grant_q;
            end else begin
                gnt_i = i_req_valid;
                gnt_d = d_req_valid;
            end
        end
    end

    // Readys are masked by reset so every output reads 0 while reset is held.
    assign i_req_ready = gnt_i & reset;
    assign d_req_ready = gnt_d & reset;
    assign final_beat  = we_q || (beat_q == LastBeat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            beat_q        <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            i_resp_valid  <= 1'b0;
            i_resp_data   <= '0;
            i_resp_last   <= 1'b0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
            d_resp_last   <= 1'b0;
        end else begin
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_i || gnt_d) begin
                        state_q       <= StReq;
                        owner_q       <= gnt_d;
                        last_grant_q  <= gnt_d;
                        mem_req_valid <= 1'b1;
                        if (gnt_d) begin
                            we_q          <= d_req_we;
                            mem_req_we    <= d_req_we;
                            mem_req_addr  <= d_req_we ? d_req_addr : (d_req_addr & LineMask);
                            mem_req_wdata <= d_req_wdata;
                            mem_req_wstrb <= d_req_we ? d_req_wstrb : '0;
                        end else begin
                            we_q          <= 1'b0;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= i_req_addr & LineMask;
                            mem_req_wdata <= '0;
                            mem_req_wstrb <= '0;
                        end
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (mem_resp_valid) begin
                        if (owner_q) begin
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= we_q ? '0 : mem_resp_data;
                            d_resp_last  <= final_beat;
                        end else begin
                            i_resp_valid <= 1'b1;
                            i_resp_data  <= mem_resp_data;
                            i_resp_last  <= final_beat;
                        end
                        beat_q <= final_beat ? '0 : beat_q + BeatW'(1);
                        if (final_beat) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef RISCV_SOFT_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (gnt_i && stat_i_grants != 32'hFFFF_FFFF) stat_i_grants <= stat_i_grants + 32'd1;
            if (gnt_d && stat_d_grants != 32'hFFFF_FFFF) stat_d_grants <= stat_d_grants + 32'd1;
            if (state_q == StIdle && i_req_valid && d_req_valid &&
                stat_conflicts != 32'hFFFF_FFFF) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Scoreboard bench for riscv_soft_mem_arbiter: random cache traffic and a random memory
// responder, checked against a transaction-level arbitration and routing model.
`timescale 1ns/1ps
module tb_riscv_soft_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LB = 4;
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] LINE_BYTES = AW'(LB * DW / 8);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req_valid, i_req_ready;
    logic [AW-1:0] i_req_addr;
    logic          i_resp_valid, i_resp_last;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid, d_req_ready, d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic [SW-1:0] d_req_wstrb;
    logic          d_resp_valid, d_resp_last;
    logic [DW-1:0] d_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [SW-1:0] mem_req_wstrb;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [31:0]   stat_i_grants, stat_d_grants, stat_conflicts;

    riscv_soft_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_last(i_resp_last),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_last(d_resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .stat_i_grants(stat_i_grants),
        .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            port;  // 1 = D
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;
    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        bit            last;
        int            cyc;
    } rsp_t;

    req_t exp_req_q[$];
    req_t pend_q[$];
    rsp_t exp_rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats_seen = 0;
    int resp_left = 0;
    bit cur_port, cur_we;
    bit rst_active = 1'b1;
    bit fixed_data = 1'b0;
    bit m_busy = 1'b0;
    bit m_last_d = 1'b1;
    int n_i_gnt = 0, n_d_gnt = 0, n_conf = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_req_q.delete();
        pend_q.delete();
        exp_rsp_q.delete();
        resp_left = 0;
        m_busy    = 1'b0;
        m_last_d  = 1'b1;
        n_i_gnt   = 0;
        n_d_gnt   = 0;
        n_conf    = 0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: random request backpressure, random beat gaps, stray beats while no txn is owed.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready = !rst_active && ($urandom_range(0, 2) != 0);
            if (rst_active) begin
                mem_resp_valid = 1'b0;
            end else if (resp_left > 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    mem_resp_data  = fixed_data ? DW'(32'hA0 + ((cur_we ? 1 : LB) - resp_left))
                                                : DW'($urandom);
                    mem_resp_valid = 1'b1;
                    exp_rsp_q.push_back('{port: cur_port, data: cur_we ? '0 : mem_resp_data,
                                          last: resp_left == 1, cyc: cyc + 1});
                    resp_left--;
                end else begin
                    mem_resp_valid = 1'b0;
                end
            end else if (pend_q.size() != 0) begin
                req_t t;
                t = pend_q.pop_front();
                cur_port       = t.port;
                cur_we         = t.we;
                resp_left      = t.we ? 1 : LB;
                mem_resp_valid = 1'b0;
            end else begin
                mem_resp_valid = ($urandom_range(0, 7) == 0);
                mem_resp_data  = DW'($urandom);
            end
        end
    end

    task automatic monitor_cycle();
        bit   ei, ed;
        rsp_t e;
        req_t r;
        if (i_resp_valid || d_resp_valid) begin
            chk(!(i_resp_valid && d_resp_valid), "resp_one_port",
                {i_resp_valid, d_resp_valid}, 0);
            chk(exp_rsp_q.size() != 0, "resp_expected", 1, 0);
            if (exp_rsp_q.size() != 0) begin
                e = exp_rsp_q.pop_front();
                chk(d_resp_valid == e.port, "resp_port", d_resp_valid, e.port);
                chk((e.port ? d_resp_data : i_resp_data) == e.data, "resp_data",
                    e.port ? d_resp_data : i_resp_data, e.data);
                chk((e.port ? d_resp_last : i_resp_last) == e.last, "resp_last",
                    e.port ? d_resp_last : i_resp_last, e.last);
                chk(cyc == e.cyc, "resp_cycle", cyc, e.cyc);
                if (e.last) m_busy = 1'b0;
                beats_seen++;
            end
        end else if (exp_rsp_q.size() != 0 && exp_rsp_q[0].cyc <= cyc) begin
            e = exp_rsp_q.pop_front();
            chk(i_resp_valid || d_resp_valid, "resp_missing", 0, 1);
            if (e.last) m_busy = 1'b0;
        end

        if (exp_req_q.size() != 0) begin
            r = exp_req_q[0];
            chk(mem_req_valid, "mreq_valid", mem_req_valid, 1);
            if (mem_req_valid) begin
                chk(mem_req_we == r.we, "mreq_we", mem_req_we, r.we);
                chk(mem_req_addr == r.addr, "mreq_addr", mem_req_addr, r.addr);
                chk(mem_req_wstrb == r.wstrb, "mreq_wstrb", mem_req_wstrb, r.wstrb);
                if (r.we) chk(mem_req_wdata == r.wdata, "mreq_wdata", mem_req_wdata, r.wdata);
                if (mem_req_ready) begin
                    void'(exp_req_q.pop_front());
                    pend_q.push_back(r);
                end
            end
        end else begin
            chk(!mem_req_valid, "mreq_spurious", mem_req_valid, 0);
        end

        ei = 1'b0;
        ed = 1'b0;
        if (!m_busy) begin
            if (i_req_valid && d_req_valid) begin
                ei = m_last_d;
                ed = !m_last_d;
                n_conf++;
            end else begin
                ei = i_req_valid;
                ed = d_req_valid;
            end
        end
        chk({i_req_ready, d_req_ready} == {ei, ed}, "req_ready",
            {i_req_ready, d_req_ready}, {ei, ed});
        if (ei || ed) begin
            if (ed) begin
                r = '{port: 1'b1, we: d_req_we,
                      addr: d_req_we ? d_req_addr : (d_req_addr & ~(LINE_BYTES - 1)),
                      wdata: d_req_wdata, wstrb: d_req_we ? d_req_wstrb : '0};
                n_d_gnt++;
            end else begin
                r = '{port: 1'b0, we: 1'b0, addr: i_req_addr & ~(LINE_BYTES - 1),
                      wdata: '0, wstrb: '0};
                n_i_gnt++;
            end
            exp_req_q.push_back(r);
            m_busy   = 1'b1;
            m_last_d = ed;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_active) monitor_cycle();
    end

    task automatic drive_i(input logic [AW-1:0] a);
        bit done = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (i_req_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        chk(done, "i_accept_timeout", done, 1);
    endtask

    task automatic drive_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws);
        bit done = 1'b0;
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_wdata = wd;
        d_req_wstrb = ws;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (d_req_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        chk(done, "d_accept_timeout", done, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 2000 && !idle; k++) begin
            @(negedge clk);
            idle = !m_busy && exp_req_q.size() == 0 && pend_q.size() == 0 &&
                   exp_rsp_q.size() == 0 && resp_left == 0;
        end
        chk(idle, "idle_timeout", idle, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        bit ok;
        ok = !(i_req_ready | d_req_ready | i_resp_valid | d_resp_valid | i_resp_last |
               d_resp_last | mem_req_valid | mem_req_we) &&
             i_resp_data == '0 && d_resp_data == '0 && mem_req_addr == '0 &&
             mem_req_wdata == '0 && mem_req_wstrb == '0 && stat_i_grants == '0 &&
             stat_d_grants == '0 && stat_conflicts == '0;
        chk(ok, name, {mem_req_valid, i_resp_valid, d_resp_valid, mem_req_addr}, 0);
    endtask

    task automatic check_stats();
`ifdef RISCV_SOFT_ARB_STATS_EN
        chk(stat_i_grants == 32'(n_i_gnt), "stat_i_grants", stat_i_grants, n_i_gnt);
        chk(stat_d_grants == 32'(n_d_gnt), "stat_d_grants", stat_d_grants, n_d_gnt);
        chk(stat_conflicts == 32'(n_conf), "stat_conflicts", stat_conflicts, n_conf);
`else
        chk(stat_i_grants == '0, "stat_i_grants", stat_i_grants, 0);
        chk(stat_d_grants == '0, "stat_d_grants", stat_d_grants, 0);
        chk(stat_conflicts == '0, "stat_conflicts", stat_conflicts, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        bit got;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        d_req_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        @(posedge clk);
        #2;
        reset      = 1'b1;
        rst_active = 1'b0;

        // Contest straight out of reset: I must win, then D, then I, D again.
        fixed_data = 1'b1;
        fork
            drive_i(32'h104);
            drive_d(1'b0, 32'h208, '0, '0);
        join
        wait_idle();
        fixed_data = 1'b0;
        fork
            drive_i(32'h33C);
            drive_d(1'b0, 32'h41C, '0, '0);
        join
        wait_idle();

        drive_d(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        wait_idle();

        fork
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                drive_i(AW'($urandom));
            end
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                drive_d(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
            end
        join
        wait_idle();
        check_stats();

        // Reset in the middle of a refill burst.
        b0 = beats_seen;
        drive_i(32'h5A0);
        got = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            got = (beats_seen >= b0 + 2);
        end
        chk(got, "burst_beats_timeout", beats_seen - b0, 2);
        @(posedge clk);
        #3;
        reset      = 1'b0;
        rst_active = 1'b1;
        clear_model();
        #1;
        check_outputs_zero("mid_burst_reset");
        repeat (2) @(posedge clk);
        #2;
        clear_model();
        reset      = 1'b1;
        rst_active = 1'b0;
        drive_d(1'b1, 32'h40, 32'h12345678, 4'h3);
        wait_idle();
        fork
            drive_i(32'h77C);
            drive_d(1'b0, 32'h880, '0, '0);
        join
        wait_idle();
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
